// File: rtl/mul_unit.sv
// Iterative shift-and-add multiplier for the Execute stage: one multiplier bit
// per cycle, producing the low 32 bits of op_a*op_b.
module mul_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        hold,
   input  logic        flush,
   output logic        ready,
   output logic [31:0] result,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, b_q, acc_q, res_q;
   logic [4:0]  count_q;
   logic [31:0] acc_sum, b_shift;
   logic        last_step;

   // Handshake: start stays high while the instruction sits in Execute; the
   // unit answers with ready, which is low from the start cycle until DONE.
   assign acc_sum   = acc_q + (b_q[0] ? a_q : 32'd0);
   assign b_shift   = b_q >> 1;
   assign last_step = (b_shift == 32'd0) || (count_q == 5'd31);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (last_step) state_d = S_DONE;
         S_DONE:  if (!hold) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         acc_q   <= 32'd0;
         count_q <= 5'd0;
         res_q   <= 32'd0;
      end else if (flush) begin
         state_q <= S_IDLE;
         acc_q   <= 32'd0;
         count_q <= 5'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  acc_q   <= 32'd0;
                  count_q <= 5'd0;
               end
            end
            S_BUSY: begin
               acc_q   <= acc_sum;
               a_q     <= a_q << 1;
               b_q     <= b_shift;
               count_q <= count_q + 5'd1;
               // Result register only changes on the way into DONE.
               if (last_step) res_q <= acc_sum;
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state_q == S_DONE) || ((state_q == S_IDLE) && !start);
   assign busy      = (state_q == S_BUSY);
   assign result    = res_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed latency/result cases plus random traffic checked
// every cycle against a latency-and-product model of the unit.
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        ready;
   logic [31:0] result;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   mul_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .hold      (hold),
      .flush     (flush),
      .ready     (ready),
      .result    (result),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
   int          m_st = M_IDLE;
   int          m_left = 0;
   bit          m_valid = 1'b0;
   bit          m_after_reset = 1'b0;
   logic [31:0] m_last = 32'd0;
   logic [31:0] exp_q[$];

   // Busy cycles = max(1, index of highest set bit of op_b + 1).
   function automatic int lat(input logic [31:0] b);
      int k = 1;
      for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
      return k;
   endfunction

   always @(posedge clk) begin
      logic [31:0] prod;
      if (reset) begin
         m_st = M_IDLE; m_last = 32'd0; exp_q.delete();
         m_valid = 1'b1; m_after_reset = 1'b1;
      end else if (m_valid) begin
         if (flush) begin
            m_st = M_IDLE; exp_q.delete();
         end else begin
            case (m_st)
               M_IDLE: if (start) begin
                  prod = op_a * op_b;
                  exp_q.push_back(prod);
                  m_left = lat(op_b);
                  m_st = M_BUSY;
               end
               M_BUSY: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_st = M_DONE;
                     m_last = exp_q.pop_front();
                     m_after_reset = 1'b0;
                  end
               end
               default: if (!hold) m_st = M_IDLE;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp_busy", busy, (m_st == M_BUSY));
         chk("cmp_ready", ready, (m_st == M_DONE) || (m_st == M_IDLE && !start));
         if (m_st == M_DONE || m_after_reset) chk("cmp_result", result, m_last);
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      start = 1'b0; hold = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Called at posedge+1; cycle 0 is the start cycle. Returns at the negedge
   // of the DONE cycle. Operands are scrambled after cycle 0.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int done_cyc, input logic h);
      start = 1'b1; op_a = a; op_b = b; hold = h;
      for (int c = 0; c <= done_cyc; c++) begin
         if (c > 0) begin
            tick();
            op_a = $urandom; op_b = $urandom;
         end
         @(negedge clk);
         if (c < done_cyc) chk("mul_ready_low", ready, 0);
         if (c == 0) chk("mul_busy_c0", busy, 0);
         else if (c < done_cyc) chk("mul_busy_high", busy, 1);
         if (c == done_cyc) begin
            chk("mul_done_ready", ready, 1);
            chk("mul_done_busy", busy, 0);
            chk("mul_result", result, exp_r);
         end
      end
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 32'd0);
      tick();

      // 7*6: DONE at cycle 4, start held so cycle 5 is IDLE restarting
      run_mul(32'd7, 32'd6, 32'd42, 4, 1'b0);
      tick();
      @(negedge clk);
      chk("a_idle_ready", ready, 0);
      chk("a_idle_busy", busy, 0);
      tick(); drain();

      // worst case latency
      run_mul(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 33, 1'b0);
      tick(); drain();

      // op_b=0 with hold: DONE at 2, held through cycle 5, IDLE at 6
      run_mul(32'h1234, 32'd0, 32'd0, 2, 1'b1);
      for (int c = 3; c <= 5; c++) begin
         tick();
         if (c == 5) hold = 1'b0;
         @(negedge clk);
         chk("hold_ready", ready, 1);
         chk("hold_result", result, 32'd0);
         chk("hold_busy", busy, 0);
      end
      tick();
      @(negedge clk);
      chk("hold_exit_ready", ready, 0);
      chk("hold_exit_busy", busy, 0);
      tick(); drain();

      // flush in the 5th BUSY cycle of 0x10000*0x10000
      start = 1'b1; op_a = 32'h1_0000; op_b = 32'h1_0000;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      tick(); flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_before", busy, 1);
      tick(); flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_after", busy, 0);
      chk("flush_ready_after", ready, 1);
      tick();
      run_mul(32'd3, 32'd5, 32'd15, 4, 1'b0);
      tick(); drain();

      // reset mid-operation
      start = 1'b1; op_a = 32'h1234; op_b = 32'hF0F0;
      tick(); start = 1'b0;
      tick();
      tick(); reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy_before", busy, 1);
      tick(); reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", ready, 1);
      chk("midrst_result", result, 32'd0);
      tick();

      // back-to-back with start held high
      run_mul(32'd2, 32'd3, 32'd6, 3, 1'b0);
      tick();
      run_mul(32'd4, 32'd5, 32'd20, 4, 1'b0);
      tick(); drain();

      // random traffic, checked by the compare process
      for (int n = 0; n < 1500; n++) begin
         start = ($urandom_range(0, 3) != 0);
         hold  = ($urandom_range(0, 2) == 0);
         flush = ($urandom_range(0, 60) == 0);
         reset = ($urandom_range(0, 200) == 0);
         op_a  = $urandom;
         op_b  = $urandom >> $urandom_range(0, 31);
         tick();
      end
      reset = 1'b0;
      drain();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The module SHALL have port start, input, 1 bit: a multiply instruction occupies the Execute stage; held high for as long as it stays there.
REQ-004 The module SHALL have port op_a, input, 32 bits: the multiplicand, sampled only in IDLE when start=1.
REQ-005 The module SHALL have port op_b, input, 32 bits: the multiplier, sampled under the same condition as op_a.
REQ-006 The module SHALL have port hold, input, 1 bit: the Execute stage is stalled by a source other than this unit.
REQ-007 The module SHALL have port flush, input, 1 bit: abort the current operation.
REQ-008 The module SHALL have port ready, output, 1 bit: the ALU has finished its operation; it drives the hazard unit's x_alu_ready input.
REQ-009 The module SHALL have port result, output, 32 bits: the low 32 bits of op_a*op_b.
REQ-010 The module SHALL have port busy, output, 1 bit: high when state is BUSY.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 ready SHALL be combinational: 1 in DONE, 1 in IDLE when start=0, and 0 otherwise; with start=1 in IDLE it SHALL be 0 in that same cycle.
REQ-013 In IDLE with start=1 and flush=0, the unit SHALL load a_reg=op_a, b_reg=op_b, acc=0 and count=0, then go to BUSY.
REQ-014 Each BUSY cycle SHALL compute acc += (b_reg[0] ? a_reg : 0) modulo 2^32, then a_reg <<= 1, b_reg >>= 1 and count += 1.
REQ-015 BUSY SHALL move to DONE after the first cycle in which the shifted b_reg == 0, or after the cycle with count==31, whichever comes first.
REQ-016 Latency SHALL be as follows, with the start cycle as cycle 0:
- DONE is reached at cycle k+1, where k = max(1, index of the highest set bit of op_b + 1).
- Worst case is op_b[31]=1, giving DONE at cycle 33.
- op_b=0 gives DONE at cycle 2.
REQ-017 In DONE, result SHALL equal acc and ready SHALL be 1.
REQ-018 DONE SHALL remain in DONE while hold=1, with result held stable, and SHALL go to IDLE on the first cycle with hold=0.
REQ-019 Back-to-back multiplies SHALL work as follows: if start is still 1 in the IDLE cycle after DONE, that cycle is treated as a new start per REQ-013, and ready=0 in it.
REQ-020 Outside DONE, result SHALL hold its last value and is not meaningful.
REQ-021 flush=1 in any state SHALL force IDLE at the next edge, clear acc and count, and discard the operation.
REQ-022 flush SHALL take priority over start, hold and completion in the same cycle.
REQ-023 During a flush cycle, ready SHALL follow REQ-012 for the current state.
REQ-024 busy SHALL be 1 only in BUSY.
REQ-025 No output SHALL depend on op_a or op_b except through registered state.
REQ-026 The low word SHALL be identical for signed and unsigned operands, so no sign handling is required.

Reset
REQ-027 reset=1 at a clock edge SHALL set state=IDLE, acc=0, a_reg=0, b_reg=0 and count=0, and result SHALL read 0 after reset.
REQ-028 reset SHALL take priority over flush, start and hold.
REQ-029 reset asserted mid-operation (in BUSY or DONE) SHALL abandon the operation, and the unit SHALL be in IDLE on the next cycle.
REQ-030 The post-reset outputs SHALL be ready=1 (with start=0), busy=0 and result=0.

Verification
REQ-031 The bench SHALL cover: op_a=7, op_b=6, start held, hold=0 -> ready=0 for cycles 0..3, DONE at cycle 4, result=42, IDLE at cycle 5.
REQ-032 The bench SHALL cover: op_a=0xFFFFFFFF, op_b=0x80000000 -> DONE at cycle 33, result=0x80000000, busy=1 for cycles 1..32.
REQ-033 The bench SHALL cover: op_b=0, op_a=0x1234 -> DONE at cycle 2, result=0; then hold=1 for 3 cycles -> result and ready stay at 0 and 1 respectively, and IDLE follows on the first cycle with hold=0.
REQ-034 The bench SHALL cover: flush=1 in the 5th BUSY cycle of 0x10000*0x10000 -> IDLE next cycle, busy=0, and a following 3*5 returns result=15 with no residue.
REQ-035 The bench SHALL cover: reset=1 asserted for one cycle during BUSY -> IDLE next cycle, result=0, and ready=1 with start=0.
REQ-036 The bench SHALL cover: two back-to-back multiplies (2*3 then 4*5) with start continuously high -> results 6 then 20, and ready=0 in the IDLE cycle between them.
